// File: rtl/eer_pkg.sv
// Shared types for the reward datapath.
//   pkt_type_t : packet type codes carried between packetFilter, node data and reward engine
//   rwState_t  : reward_ctrl sequencer states
//   isRewardType() : true for the packet types that launch a reward job
package eer_pkg;

  typedef enum logic [2:0] {
    PKT_NONE    = 3'd0,
    PKT_HB      = 3'd1,
    PKT_CHE     = 3'd2,
    PKT_CLUSTER = 3'd3,
    PKT_MEMREQ  = 3'd4,
    PKT_INV     = 3'd5,
    PKT_DATA    = 3'd6
  } pkt_type_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_TX    = 2'd3
  } rwState_t;

  // NONE and the unused code 3'd7 never start a job.
  function automatic logic isRewardType(input logic [2:0] t);
    return (t >= 3'(PKT_HB)) && (t <= 3'(PKT_DATA));
  endfunction

endpackage

// File: rtl/reward_ctrl_if.sv
// Handshake bundle around reward_ctrl.
//   rx_*        : receive path from packetFilter (valid/ready)
//   local_*     : level request from node data logic, grant pulse back
//   rw_*        : reward engine start, packet type, done pulse
//   tx_*        : built packet handoff to transmit path (valid/ready)
//   busy, timeout_err : status
// Modports: slave = reward_ctrl's view, master = surrounding logic's view.
interface reward_ctrl_if;

  logic       rx_valid;
  logic [2:0] rx_type;
  logic       rx_is_dest;
  logic       rx_ready;
  logic       local_req;
  logic       local_ack;
  logic       rw_en;
  logic [2:0] rw_pkt_type;
  logic       rw_done;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       timeout_err;

  modport slave (
    input  rx_valid, rx_type, rx_is_dest, local_req, rw_done, tx_ready,
    output rx_ready, local_ack, rw_en, rw_pkt_type, tx_valid, busy, timeout_err
  );

  modport master (
    output rx_valid, rx_type, rx_is_dest, local_req, rw_done, tx_ready,
    input  rx_ready, local_ack, rw_en, rw_pkt_type, tx_valid, busy, timeout_err
  );

endinterface

// File: rtl/reward_ctrl_arb.sv
// Arbiter between the rx path and the local data source.
// Qualifies/drops rx packets, keeps the rx streak counter and picks the grant.
// Ports:
//   clk, rst         : clock, async active-high reset
//   idle             : sequencer is in IDLE (and not in reset)
//   rxValid/rxType/rxIsDest : pending rx packet
//   localReq         : local data request (level)
//   rxReady          : rx packet consumed this cycle (grant or drop)
//   localAck         : local grant pulse
//   grantRx/grantLocal : job granted this cycle
module reward_ctrl_arb
  import eer_pkg::*;
#(
  parameter int MAX_RX_STREAK = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       idle,
  input  logic       rxValid,
  input  logic [2:0] rxType,
  input  logic       rxIsDest,
  input  logic       localReq,
  output logic       rxReady,
  output logic       localAck,
  output logic       grantRx,
  output logic       grantLocal
);

  localparam int STREAK_W = $clog2(MAX_RX_STREAK + 1);

  logic [STREAK_W-1:0] streak;
  logic                streakSat;
  logic                rxQual;
  logic                localWins;

  // DATA addressed to this node terminates here, so it is a drop, not a job.
  assign rxQual    = rxValid && isRewardType(rxType)
                     && !((rxType == 3'(PKT_DATA)) && rxIsDest);
  assign streakSat = (streak >= STREAK_W'(MAX_RX_STREAK));
  assign localWins = localReq && (!rxQual || streakSat);

  assign rxReady    = idle && rxValid && !localWins;
  assign grantRx    = idle && rxQual && !localWins;
  assign grantLocal = idle && localWins;
  assign localAck   = grantLocal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak <= '0;
    end else if (grantLocal) begin
      streak <= '0;
    end else if (grantRx && !streakSat) begin
      streak <= streak + 1'b1;
    end
  end

endmodule

// File: rtl/reward_ctrl.sv
// Reward datapath sequencer: arbitrates rx/local jobs, fires the reward
// engine once per job, waits for done, then offers the packet to tx.
// Ports:
//   clk, rst : clock, async active-high reset
//   bus      : reward_ctrl_if.slave (rx, local, reward engine, tx, status)
// Optional feature: define REWARD_CTRL_TIMEOUT_EN to enable the WAIT-state
// watchdog (TIMEOUT_CYCLES); otherwise WAIT holds until rw_done.
module reward_ctrl
  import eer_pkg::*;
#(
  parameter int MAX_RX_STREAK  = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic          clk,
  input  logic          rst,
  reward_ctrl_if.slave  bus
);

  rwState_t   state, stateNext;
  logic [2:0] pktType, pktTypeNext;
  logic       idle;
  logic       grantRx, grantLocal;
  logic       wdExpire;

  // Gating with rst keeps rx_ready/local_ack low while reset is held.
  assign idle = (state == ST_IDLE) && !rst;

  reward_ctrl_arb #(
    .MAX_RX_STREAK(MAX_RX_STREAK)
  ) u_arb (
    .clk        (clk),
    .rst        (rst),
    .idle       (idle),
    .rxValid    (bus.rx_valid),
    .rxType     (bus.rx_type),
    .rxIsDest   (bus.rx_is_dest),
    .localReq   (bus.local_req),
    .rxReady    (bus.rx_ready),
    .localAck   (bus.local_ack),
    .grantRx    (grantRx),
    .grantLocal (grantLocal)
  );

`ifdef REWARD_CTRL_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wdCnt;

  // Counts completed WAIT cycles; zero in the first WAIT cycle, so the
  // TIMEOUT_CYCLES-th WAIT cycle is the expiry cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdCnt <= '0;
    end else if (state != ST_WAIT) begin
      wdCnt <= '0;
    end else begin
      wdCnt <= wdCnt + 1'b1;
    end
  end

  assign wdExpire        = (state == ST_WAIT) && (wdCnt == WD_W'(TIMEOUT_CYCLES - 1));
  assign bus.timeout_err = wdExpire && !bus.rw_done;
`else
  logic unusedTimeoutCfg;
  assign unusedTimeoutCfg = (TIMEOUT_CYCLES != 0);
  assign wdExpire         = 1'b0;
  assign bus.timeout_err  = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      pktType <= 3'(PKT_NONE);
    end else begin
      state   <= stateNext;
      pktType <= pktTypeNext;
    end
  end

  always_comb begin
    stateNext   = state;
    pktTypeNext = pktType;
    case (state)
      ST_IDLE: begin
        if (grantLocal) begin
          stateNext   = ST_ISSUE;
          pktTypeNext = 3'(PKT_DATA);
        end else if (grantRx) begin
          stateNext   = ST_ISSUE;
          pktTypeNext = bus.rx_type;
        end
      end
      ST_ISSUE: stateNext = ST_WAIT;
      ST_WAIT: begin
        // done on the expiry cycle takes priority over the watchdog
        if (bus.rw_done) begin
          stateNext = ST_TX;
        end else if (wdExpire) begin
          stateNext   = ST_IDLE;
          pktTypeNext = 3'(PKT_NONE);
        end
      end
      ST_TX: begin
        if (bus.tx_ready) begin
          stateNext   = ST_IDLE;
          pktTypeNext = 3'(PKT_NONE);
        end
      end
      default: begin
        stateNext   = ST_IDLE;
        pktTypeNext = 3'(PKT_NONE);
      end
    endcase
  end

  assign bus.rw_en       = (state == ST_ISSUE);
  assign bus.tx_valid    = (state == ST_TX);
  assign bus.busy        = (state != ST_IDLE);
  assign bus.rw_pkt_type = pktType;

endmodule
